dense_mac_layer: RTL and testbench

Streaming multiply-accumulate neuron layer that produces the four signed 12-bit pre-activation outputs `y4`..`y7` consumed directly by the ReLU stage. Each frame streams one signed activation per beat, together with the four matching weights. The block accumulates one dot product per output neuron, then scales and saturates each result to 12 bits. It registers the four results and pulses `out_valid` once per frame.

---
 rtl/dense_mac_layer_pkg.sv | 36 +++
 rtl/dense_mac_layer_if.sv | 31 +++
 rtl/dense_mac_layer_mac_lane.sv | 52 +++++
 rtl/dense_mac_layer.sv | 138 +++++++++++++
 tb/tb_dense_mac_layer.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/dense_mac_layer_pkg.sv
// Shared neural-layer definitions: datapath widths, MAC sequencing states and
// the shift-and-saturate helper reused by later layers.
package dnn_pkg;

    localparam int DATA_W     = 8;
    localparam int ACC_W      = 20;
    localparam int OUT_W      = 12;
    localparam int FRAC_SHIFT = 4;
    localparam int MAX_TERMS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    // Arithmetic shift floors toward negative infinity; the clamp then folds
    // the value into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] acc,
        input int unsigned             shift
    );
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> shift;
        if (sh > SAT_HI) begin
            sh = SAT_HI;
        end else if (sh < SAT_LO) begin
            sh = SAT_LO;
        end
        return sh[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dense_mac_layer_if.sv
// Beat/result bundle between the activation stream source and the MAC layer;
// the layer sits on the slave side.
interface dense_mac_layer_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12
);
    logic                     in_valid;
    logic                     in_last;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w4;
    logic signed [DATA_W-1:0] w5;
    logic signed [DATA_W-1:0] w6;
    logic signed [DATA_W-1:0] w7;
    logic                     busy;
    logic signed [OUT_W-1:0]  y4;
    logic signed [OUT_W-1:0]  y5;
    logic signed [OUT_W-1:0]  y6;
    logic signed [OUT_W-1:0]  y7;
    logic                     out_valid;
    logic                     err;

    modport master (
        output in_valid, in_last, x, w4, w5, w6, w7,
        input  busy, y4, y5, y6, y7, out_valid, err
    );

    modport slave (
        input  in_valid, in_last, x, w4, w5, w6, w7,
        output busy, y4, y5, y6, y7, out_valid, err
    );
endinterface

// File: rtl/dense_mac_layer_mac_lane.sv
// One neuron accumulator: load/add/hold of x*w, with the scaled and saturated
// result captured into an output register on request.
module mac_lane #(
    parameter int          DATA_W     = 8,
    parameter int          ACC_W      = 20,
    parameter int          OUT_W      = 12,
    parameter int unsigned FRAC_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     add_i,
    input  logic                     cap_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [OUT_W-1:0]  y_o
);
    import dnn_pkg::*;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [OUT_W-1:0]    y_q;

    assign prod     = x_i * w_i;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = prod_ext;
        end else if (add_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (cap_i) begin
                y_q <= sat_shift(acc_q, FRAC_SHIFT);
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/dense_mac_layer.sv
// Four-neuron streaming MAC layer: frame sequencing, beat counting and
// forced-termination flag around four accumulator lanes.
module dense_mac_layer #(
    parameter int          DATA_W     = 8,
    parameter int          ACC_W      = 20,
    parameter int          OUT_W      = 12,
    parameter int unsigned FRAC_SHIFT = 4,
    parameter int          MAX_TERMS  = 16
) (
    input logic               clk,
    input logic               rst,
    dense_mac_layer_if.slave  bus
);
    import dnn_pkg::*;

    localparam int N_LANES = 4;
    localparam int CNT_W   = $clog2(MAX_TERMS + 1);

    mac_state_t       state_q;
    mac_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_flag_q;
    logic             err_flag_d;
    logic             out_valid_q;
    logic             err_q;

    logic             final_beat;
    logic             load_en;
    logic             add_en;
    logic             cap_en;
    logic             busy;

    logic signed [DATA_W-1:0] w_arr [N_LANES];
    logic signed [OUT_W-1:0]  y_arr [N_LANES];

    // cnt_q is zero whenever IDLE, so the limit test holds for both states.
    assign final_beat = bus.in_last || ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (bus.in_valid) begin
                    state_d = final_beat ? DONE : ACCUM;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        add_en  = 1'b0;
        cap_en  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE:  load_en = bus.in_valid;
            ACCUM: add_en  = bus.in_valid;
            DONE: begin
                cap_en = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        if (load_en) begin
            cnt_d      = CNT_W'(1);
            err_flag_d = final_beat && !bus.in_last;
        end else if (add_en) begin
            cnt_d      = cnt_q + CNT_W'(1);
            err_flag_d = final_beat && !bus.in_last;
        end else if (cap_en) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            out_valid_q <= cap_en;
            err_q       <= cap_en && err_flag_q;
        end
    end

    assign w_arr[0] = bus.w4;
    assign w_arr[1] = bus.w5;
    assign w_arr[2] = bus.w6;
    assign w_arr[3] = bus.w7;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            mac_lane #(
                .DATA_W     (DATA_W),
                .ACC_W      (ACC_W),
                .OUT_W      (OUT_W),
                .FRAC_SHIFT (FRAC_SHIFT)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .load_i (load_en),
                .add_i  (add_en),
                .cap_i  (cap_en),
                .x_i    (bus.x),
                .w_i    (w_arr[gi]),
                .y_o    (y_arr[gi])
            );
        end
    endgenerate

    assign bus.y4        = y_arr[0];
    assign bus.y5        = y_arr[1];
    assign bus.y6        = y_arr[2];
    assign bus.y7        = y_arr[3];
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed-vector bench for dense_mac_layer: hand-computed results, pulse
// timing, forced termination, dropped DONE beats and mid-frame reset.
module tb_dense_mac_layer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    dense_mac_layer_if #(.DATA_W(8), .OUT_W(12)) bus ();

    dense_mac_layer #(
        .DATA_W     (8),
        .ACC_W      (20),
        .OUT_W      (12),
        .FRAC_SHIFT (4),
        .MAX_TERMS  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (or idle cycle) and advance past the accepting edge.
    task automatic drive(input int v, input int last, input int xv,
                         input int a4, input int a5, input int a6, input int a7);
        bus.in_valid = v[0];
        bus.in_last  = last[0];
        bus.x        = 8'(xv);
        bus.w4       = 8'(a4);
        bus.w5       = 8'(a5);
        bus.w6       = 8'(a6);
        bus.w7       = 8'(a7);
        step();
    endtask

    // Called one cycle after the final beat edge: state is DONE here.
    task automatic finish_frame(input string tag, input int e4, input int e5,
                                input int e6, input int e7, input int e_err);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({tag, ".ov_early"}, int'(bus.out_valid), 0);
        check({tag, ".busy"}, int'(bus.busy), 1);
        step();
        check({tag, ".ov"}, int'(bus.out_valid), 1);
        check({tag, ".y4"}, int'(bus.y4), e4);
        check({tag, ".y5"}, int'(bus.y5), e5);
        check({tag, ".y6"}, int'(bus.y6), e6);
        check({tag, ".y7"}, int'(bus.y7), e7);
        check({tag, ".err"}, int'(bus.err), e_err);
        step();
        check({tag, ".ov_off"}, int'(bus.out_valid), 0);
        check({tag, ".err_off"}, int'(bus.err), 0);
        check({tag, ".busy_off"}, int'(bus.busy), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.x  = '0;
        bus.w4 = '0;
        bus.w5 = '0;
        bus.w6 = '0;
        bus.w7 = '0;
        repeat (3) step();
        check("rst.y4", int'(bus.y4), 0);
        check("rst.ov", int'(bus.out_valid), 0);
        check("rst.busy", int'(bus.busy), 0);
        check("rst.err", int'(bus.err), 0);
        rst = 1'b0;
        step();

        // 4 x (16*16) = 1024, >>>4 = 64
        for (int i = 0; i < 4; i++) drive(1, (i == 3) ? 1 : 0, 16, 16, 0, 0, 0);
        finish_frame("t1", 64, 0, 0, 0, 0);

        // 16 x 16129 forced termination, saturates high
        for (int i = 0; i < 16; i++) drive(1, 0, 127, 127, 127, 127, 127);
        finish_frame("t2", 2047, 2047, 2047, 2047, 1);

        // 16 x -16256 with in_last, saturates low
        for (int i = 0; i < 16; i++) drive(1, (i == 15) ? 1 : 0, -128, 127, 127, 127, 127);
        finish_frame("t3", -2048, -2048, -2048, -2048, 0);

        // -1 >>> 4 floors to -1; 15 >>> 4 = 0
        drive(1, 1, -1, 1, 0, 0, 0);
        finish_frame("t4a", -1, 0, 0, 0, 0);
        drive(1, 1, 3, 5, 0, 0, 0);
        finish_frame("t4b", 0, 0, 0, 0, 0);

        // 3 beats of 2*8 with 3-cycle gaps: 48 >>> 4 = 3
        drive(1, 0, 2, 0, 0, 8, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 2, 0, 0, 8, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 0, 0, 8, 0);
        check("t5.busy", int'(bus.busy), 1);
        drive(1, 1, 100, 0, 0, 100, 100);   // presented during DONE, must be dropped
        check("t5.ov", int'(bus.out_valid), 1);
        check("t5.y6", int'(bus.y6), 3);
        check("t5.y7", int'(bus.y7), 0);
        check("t5.busy_idle", int'(bus.busy), 0);
        // back-to-back frame: 4*8 = 32 >>> 4 = 2
        drive(1, 1, 4, 0, 0, 0, 8);
        finish_frame("t5b", 0, 0, 0, 2, 0);

        // mid-frame reset discards the partial frame
        drive(1, 0, 1, 0, 2, 0, 0);
        drive(1, 0, 1, 0, 2, 0, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6.rst_y7", int'(bus.y7), 0);
        check("t6.rst_busy", int'(bus.busy), 0);
        check("t6.rst_ov", int'(bus.out_valid), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6.no_ov", int'(bus.out_valid), 0);
        end
        for (int i = 0; i < 4; i++) drive(1, (i == 3) ? 1 : 0, 1, 0, 2, 0, 0);
        finish_frame("t6", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
